// File: rtl/free_id_queue_pkg.sv
// -----------------------------------------------------------------------------
// free_id_queue_pkg
//   Shared definitions for the free-ID queue: default parameter values and the
//   preload function that produces the power-on / flush contents of each entry.
//   The same function is used by the storage array and by verification code so
//   that the preload pattern has a single definition.
// -----------------------------------------------------------------------------
package free_id_queue_pkg;

  localparam int DEF_ID_W        = 5;
  localparam int DEF_DEPTH       = 8;
  localparam int DEF_NRD         = 2;
  localparam int DEF_NWR         = 2;
  localparam int DEF_INIT_BASE   = 1;
  localparam int DEF_INIT_STRIDE = 4;

  // Preload value of entry 'index': (base + index*stride) mod 2^width.
  function automatic int unsigned preload_id(input int unsigned base,
                                             input int unsigned stride,
                                             input int unsigned index,
                                             input int unsigned width);
    int unsigned mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (base + index * stride) & mask;
  endfunction

endpackage

// File: rtl/free_id_store.sv
// -----------------------------------------------------------------------------
// free_id_store
//   DEPTH x ID_W storage array for the free-ID queue.
//   - NRD combinational read ports (index in, data out).
//   - NWR write ports, each with its own enable, index and data.
//   - Contents return to the preload pattern on reset (asynchronous) or when
//     'restore' is high at a clock edge; restore overrides any write.
//
//   Ports
//     clk      in   clock, rising edge
//     rst_n    in   asynchronous active-low reset
//     restore  in   synchronous reload of the preload pattern
//     rd_idx   in   NRD*PTR_W  read indices, port p in [p*PTR_W +: PTR_W]
//     rd_data  out  NRD*ID_W   read data,    port p in [p*ID_W  +: ID_W]
//     wr_en    in   NWR        per-port write enable
//     wr_idx   in   NWR*PTR_W  write indices (distinct when enabled together)
//     wr_data  in   NWR*ID_W   write data
// -----------------------------------------------------------------------------
module free_id_store
  import free_id_queue_pkg::*;
#(
  parameter int ID_W        = DEF_ID_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int NRD         = DEF_NRD,
  parameter int NWR         = DEF_NWR,
  parameter int INIT_BASE   = DEF_INIT_BASE,
  parameter int INIT_STRIDE = DEF_INIT_STRIDE,
  parameter int PTR_W       = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  restore,
  input  logic [NRD*PTR_W-1:0]  rd_idx,
  output logic [NRD*ID_W-1:0]   rd_data,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*PTR_W-1:0]  wr_idx,
  input  logic [NWR*ID_W-1:0]   wr_data
);

  logic [ID_W-1:0] mem [DEPTH];

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NRD; p++) begin
      rd_data[p*ID_W +: ID_W] = mem[rd_idx[p*PTR_W +: PTR_W]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= ID_W'(preload_id(INIT_BASE, INIT_STRIDE, i, ID_W));
      end
    end else if (restore) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= ID_W'(preload_id(INIT_BASE, INIT_STRIDE, i, ID_W));
      end
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p]) begin
          mem[wr_idx[p*PTR_W +: PTR_W]] <= wr_data[p*ID_W +: ID_W];
        end
      end
    end
  end

endmodule

// File: rtl/free_id_queue.sv
// -----------------------------------------------------------------------------
// free_id_queue
//   Multi-port circular queue of free IDs. Starts full with a preloaded ID
//   pattern; consumers pop up to NRD IDs per cycle (all-or-nothing), producers
//   return up to NWR IDs per cycle. Pointers wrap modulo DEPTH so any depth
//   from 2 to 64 is supported.
//
//   Ports
//     Clk       in   clock, rising edge
//     Rest      in   asynchronous active-low reset
//     RdReq     in   NRD        pop request, contiguous from bit 0
//     RdGrant   out  1          combinational: the requested pops are accepted
//     RdId      out  NRD*ID_W   registered popped IDs
//     RdValid   out  NRD        registered per-port valid for RdId
//     PreId     out  NRD*ID_W   combinational lookahead of the next NRD IDs
//     WrReq     in   NWR        push request, contiguous from bit 0
//     WrId      in   NWR*ID_W   IDs to push, port order = queue order
//     Flush     in   1          restore the preloaded full state
//     Count     out  CNT_W      registered occupancy
//     Full      out  1          Count == DEPTH
//     Empty     out  1          Count == 0
//     Overflow  out  1          sticky: a push was rejected
// -----------------------------------------------------------------------------
module free_id_queue
  import free_id_queue_pkg::*;
#(
  parameter int ID_W        = DEF_ID_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int NRD         = DEF_NRD,
  parameter int NWR         = DEF_NWR,
  parameter int INIT_BASE   = DEF_INIT_BASE,
  parameter int INIT_STRIDE = DEF_INIT_STRIDE
) (
  input  logic                         Clk,
  input  logic                         Rest,
  input  logic [NRD-1:0]               RdReq,
  output logic                         RdGrant,
  output logic [NRD*ID_W-1:0]          RdId,
  output logic [NRD-1:0]               RdValid,
  output logic [NRD*ID_W-1:0]          PreId,
  input  logic [NWR-1:0]               WrReq,
  input  logic [NWR*ID_W-1:0]          WrId,
  input  logic                         Flush,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic                         Full,
  output logic                         Empty,
  output logic                         Overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int KR_W  = $clog2(NRD + 1);
  localparam int KW_W  = $clog2(NWR + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Pointer advance modulo DEPTH. ptr < DEPTH and inc <= DEPTH, so one
  // conditional subtraction is enough and no power-of-two wrap is assumed.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr,
                                               input int unsigned       inc);
    logic [PTR_W:0] s;
    s = {1'b0, ptr} + (PTR_W+1)'(inc);
    if (s >= (PTR_W+1)'(DEPTH)) begin
      s = s - (PTR_W+1)'(DEPTH);
    end
    return s[PTR_W-1:0];
  endfunction

  logic [PTR_W-1:0]       head;
  logic [PTR_W-1:0]       tail;
  logic [CNT_W-1:0]       count;
  logic                   ovf;

  logic [KR_W-1:0]        kr;
  logic [KW_W-1:0]        kw;
  logic [CNT_W-1:0]       kr_c;
  logic [CNT_W-1:0]       kw_c;
  logic [NRD-1:0]         rd_mask;
  logic [NWR-1:0]         wr_mask;
  logic                   pop_ok;
  logic                   push_ok;
  logic                   push_rej;
  logic [CNT_W-1:0]       count_next;

  logic [NRD*PTR_W-1:0]   rd_idx;
  logic [NRD*ID_W-1:0]    rd_data;
  logic [NWR-1:0]         wr_en;
  logic [NWR*PTR_W-1:0]   wr_idx;

  logic [NRD*ID_W-1:0]    rd_id_p1;
  logic [NRD-1:0]         rd_vld_p1;

  // ---- stage 0: request decode, grant/accept, storage addressing ----------
  always_comb begin
    kr      = '0;
    kw      = '0;
    rd_mask = '0;
    wr_mask = '0;
    for (int p = 0; p < NRD; p++) begin
      kr = kr + KR_W'(RdReq[p]);
    end
    for (int p = 0; p < NWR; p++) begin
      kw = kw + KW_W'(WrReq[p]);
    end
    // Ports below the popcount are the ones that carry data; this also keeps
    // the port mapping well-defined if a request were ever non-contiguous.
    for (int p = 0; p < NRD; p++) begin
      rd_mask[p] = (KR_W'(p) < kr);
    end
    for (int p = 0; p < NWR; p++) begin
      wr_mask[p] = (KW_W'(p) < kw);
    end
  end

  assign kr_c = CNT_W'(kr);
  assign kw_c = CNT_W'(kw);

  // Both decisions use the pre-cycle count: a pop in the same cycle does not
  // make room for a push.
  assign pop_ok   = (kr != '0) && (count >= kr_c);
  assign push_ok  = (kw != '0) && ((DEPTH_C - count) >= kw_c);
  assign push_rej = (kw != '0) && !push_ok;

  assign count_next = count - (pop_ok ? kr_c : '0) + (push_ok ? kw_c : '0);

  always_comb begin
    rd_idx = '0;
    wr_idx = '0;
    wr_en  = '0;
    for (int p = 0; p < NRD; p++) begin
      rd_idx[p*PTR_W +: PTR_W] = ptr_add(head, p);
    end
    for (int p = 0; p < NWR; p++) begin
      wr_idx[p*PTR_W +: PTR_W] = ptr_add(tail, p);
      wr_en[p]                 = push_ok && wr_mask[p] && !Flush;
    end
  end

  free_id_store #(
    .ID_W        (ID_W),
    .DEPTH       (DEPTH),
    .NRD         (NRD),
    .NWR         (NWR),
    .INIT_BASE   (INIT_BASE),
    .INIT_STRIDE (INIT_STRIDE),
    .PTR_W       (PTR_W)
  ) u_store (
    .clk     (Clk),
    .rst_n   (Rest),
    .restore (Flush),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (WrId)
  );

  // ---- stage 1: pointer/count update and registered pop outputs -----------
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      head      <= '0;
      tail      <= '0;
      count     <= DEPTH_C;
      ovf       <= 1'b0;
      rd_vld_p1 <= '0;
      rd_id_p1  <= '0;
    end else if (Flush) begin
      // Flush wins over everything; RdId deliberately keeps its last value.
      head      <= '0;
      tail      <= '0;
      count     <= DEPTH_C;
      ovf       <= 1'b0;
      rd_vld_p1 <= '0;
    end else begin
      if (pop_ok) begin
        head <= ptr_add(head, 32'(kr));
        for (int p = 0; p < NRD; p++) begin
          if (rd_mask[p]) begin
            rd_id_p1[p*ID_W +: ID_W] <= rd_data[p*ID_W +: ID_W];
          end
        end
      end
      rd_vld_p1 <= pop_ok ? rd_mask : '0;
      if (push_ok) begin
        tail <= ptr_add(tail, 32'(kw));
      end
      count <= count_next;
      if (push_rej) begin
        ovf <= 1'b1;
      end
    end
  end

  assign RdGrant  = pop_ok;
  assign RdId     = rd_id_p1;
  assign RdValid  = rd_vld_p1;
  assign PreId    = rd_data;
  assign Count    = count;
  assign Full     = (count == DEPTH_C);
  assign Empty    = (count == '0);
  assign Overflow = ovf;

endmodule

// File: tb/tb_free_id_queue.sv
// -----------------------------------------------------------------------------
// tb_free_id_queue
//   Directed bench for free_id_queue at default parameters (DEPTH=8, ID_W=5,
//   NRD=NWR=2, preload 1,5,9,...,29). A table of per-cycle vectors carries the
//   inputs and hand-computed expected state; a hand-written sequence covers an
//   asynchronous reset pulse between clock edges.
// -----------------------------------------------------------------------------
module tb_free_id_queue;
  import free_id_queue_pkg::*;

  logic        Clk = 1'b0;
  logic        Rest;
  logic [1:0]  RdReq;
  logic        RdGrant;
  logic [9:0]  RdId;
  logic [1:0]  RdValid;
  logic [9:0]  PreId;
  logic [1:0]  WrReq;
  logic [9:0]  WrId;
  logic        Flush;
  logic [3:0]  Count;
  logic        Full;
  logic        Empty;
  logic        Overflow;

  free_id_queue dut (
    .Clk      (Clk),
    .Rest     (Rest),
    .RdReq    (RdReq),
    .RdGrant  (RdGrant),
    .RdId     (RdId),
    .RdValid  (RdValid),
    .PreId    (PreId),
    .WrReq    (WrReq),
    .WrId     (WrId),
    .Flush    (Flush),
    .Count    (Count),
    .Full     (Full),
    .Empty    (Empty),
    .Overflow (Overflow)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0] rd;
    logic [1:0] wr;
    logic [4:0] w0;
    logic [4:0] w1;
    logic       fl;
    logic       g;      // expected RdGrant during the cycle
    logic [1:0] vld;    // expected RdValid after the edge
    logic [4:0] id0;
    logic [4:0] id1;
    logic [1:0] idchk;  // which RdId ports to compare
    logic [3:0] cnt;
    logic       ovf;
    logic [4:0] p0;
    logic [4:0] p1;
    logic [1:0] pchk;   // which PreId ports to compare
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic void add(input logic [1:0] rd, input logic [1:0] wr,
                              input logic [4:0] w0, input logic [4:0] w1,
                              input logic fl, input logic g, input logic [1:0] vld,
                              input logic [4:0] id0, input logic [4:0] id1,
                              input logic [1:0] idchk, input logic [3:0] cnt,
                              input logic ovf, input logic [4:0] p0,
                              input logic [4:0] p1, input logic [1:0] pchk);
    vec_t v;
    v = '{rd, wr, w0, w1, fl, g, vld, id0, id1, idchk, cnt, ovf, p0, p1, pchk};
    vecs.push_back(v);
  endfunction

  initial begin
    // rd    wr    w0  w1  fl g  vld   id0 id1 idchk cnt ovf p0  p1  pchk
    add(2'b11, 2'b00, 0,  0,  0, 1, 2'b11, 1,  5,  2'b11, 6, 0, 9,  13, 2'b11);
    add(2'b11, 2'b00, 0,  0,  0, 1, 2'b11, 9,  13, 2'b11, 4, 0, 17, 21, 2'b11);
    add(2'b11, 2'b00, 0,  0,  0, 1, 2'b11, 17, 21, 2'b11, 2, 0, 25, 29, 2'b11);
    add(2'b11, 2'b00, 0,  0,  0, 1, 2'b11, 25, 29, 2'b11, 0, 0, 0,  0,  2'b00);
    add(2'b11, 2'b00, 0,  0,  0, 0, 2'b00, 25, 29, 2'b11, 0, 0, 0,  0,  2'b00);
    add(2'b00, 2'b11, 3,  7,  0, 0, 2'b00, 25, 29, 2'b11, 2, 0, 3,  7,  2'b11);
    add(2'b00, 2'b11, 10, 11, 0, 0, 2'b00, 25, 29, 2'b11, 4, 0, 3,  7,  2'b11);
    add(2'b00, 2'b11, 12, 13, 0, 0, 2'b00, 25, 29, 2'b11, 6, 0, 3,  7,  2'b11);
    add(2'b00, 2'b11, 14, 15, 0, 0, 2'b00, 25, 29, 2'b11, 8, 0, 3,  7,  2'b11);
    add(2'b11, 2'b00, 0,  0,  0, 1, 2'b11, 3,  7,  2'b11, 6, 0, 10, 11, 2'b11);
    add(2'b11, 2'b00, 0,  0,  0, 1, 2'b11, 10, 11, 2'b11, 4, 0, 12, 13, 2'b11);
    add(2'b00, 2'b11, 20, 21, 0, 0, 2'b00, 10, 11, 2'b11, 6, 0, 12, 13, 2'b11);
    add(2'b11, 2'b00, 0,  0,  0, 1, 2'b11, 12, 13, 2'b11, 4, 0, 14, 15, 2'b11);
    add(2'b11, 2'b00, 0,  0,  0, 1, 2'b11, 14, 15, 2'b11, 2, 0, 20, 21, 2'b11);
    add(2'b11, 2'b00, 0,  0,  0, 1, 2'b11, 20, 21, 2'b11, 0, 0, 0,  0,  2'b00);
    add(2'b00, 2'b01, 9,  0,  0, 0, 2'b00, 20, 21, 2'b11, 1, 0, 9,  0,  2'b01);
    add(2'b11, 2'b00, 0,  0,  0, 0, 2'b00, 20, 21, 2'b11, 1, 0, 9,  0,  2'b01);
    add(2'b01, 2'b00, 0,  0,  0, 1, 2'b01, 9,  0,  2'b01, 0, 0, 0,  0,  2'b00);
    add(2'b01, 2'b01, 6,  0,  0, 0, 2'b00, 9,  0,  2'b01, 1, 0, 6,  0,  2'b01);
    add(2'b00, 2'b00, 0,  0,  1, 0, 2'b00, 9,  0,  2'b01, 8, 0, 1,  5,  2'b11);
    add(2'b01, 2'b01, 5,  0,  0, 1, 2'b01, 1,  0,  2'b01, 7, 1, 5,  9,  2'b11);
    add(2'b00, 2'b11, 2,  3,  0, 0, 2'b00, 1,  0,  2'b01, 7, 1, 5,  9,  2'b11);
    add(2'b11, 2'b00, 0,  0,  1, 1, 2'b00, 1,  0,  2'b01, 8, 0, 1,  5,  2'b11);
    add(2'b11, 2'b11, 30, 31, 0, 1, 2'b11, 1,  5,  2'b11, 6, 1, 9,  13, 2'b11);
    add(2'b11, 2'b11, 30, 31, 0, 1, 2'b11, 9,  13, 2'b11, 6, 1, 17, 21, 2'b11);
    add(2'b00, 2'b00, 0,  0,  1, 0, 2'b00, 9,  13, 2'b11, 8, 0, 1,  5,  2'b11);

    // Reset state
    Rest  = 1'b0;
    RdReq = '0;
    WrReq = '0;
    WrId  = '0;
    Flush = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_count",    Count,    8);
    chk("rst_full",     Full,     1);
    chk("rst_empty",    Empty,    0);
    chk("rst_valid",    RdValid,  0);
    chk("rst_rdid",     RdId,     0);
    chk("rst_overflow", Overflow, 0);
    chk("rst_preid0",   PreId[4:0], preload_id(1, 4, 0, 5));
    chk("rst_preid1",   PreId[9:5], preload_id(1, 4, 1, 5));
    Rest = 1'b1;

    // Table-driven cycles: inputs applied just after an edge, grant checked
    // mid-cycle, registered state checked just after the next edge.
    for (int i = 0; i < vecs.size(); i++) begin
      RdReq = vecs[i].rd;
      WrReq = vecs[i].wr;
      WrId  = {vecs[i].w1, vecs[i].w0};
      Flush = vecs[i].fl;
      #1;
      chk($sformatf("v%0d_grant", i), RdGrant, vecs[i].g);
      @(posedge Clk);
      #1;
      RdReq = '0;
      WrReq = '0;
      Flush = 1'b0;
      chk($sformatf("v%0d_valid", i), RdValid, vecs[i].vld);
      if (vecs[i].idchk[0]) chk($sformatf("v%0d_rdid0", i), RdId[4:0], vecs[i].id0);
      if (vecs[i].idchk[1]) chk($sformatf("v%0d_rdid1", i), RdId[9:5], vecs[i].id1);
      chk($sformatf("v%0d_count", i), Count, vecs[i].cnt);
      chk($sformatf("v%0d_full", i),  Full,  (vecs[i].cnt == 4'd8));
      chk($sformatf("v%0d_empty", i), Empty, (vecs[i].cnt == 4'd0));
      chk($sformatf("v%0d_overflow", i), Overflow, vecs[i].ovf);
      if (vecs[i].pchk[0]) chk($sformatf("v%0d_preid0", i), PreId[4:0], vecs[i].p0);
      if (vecs[i].pchk[1]) chk($sformatf("v%0d_preid1", i), PreId[9:5], vecs[i].p1);
    end

    // Asynchronous reset pulsed between edges while pops are in progress.
    RdReq = 2'b11;
    @(posedge Clk);
    #1;
    chk("ar_pre_rdid0", RdId[4:0], 1);
    chk("ar_pre_count", Count, 6);
    #2;
    Rest = 1'b0;
    #1;
    chk("ar_count",    Count,    8);
    chk("ar_valid",    RdValid,  0);
    chk("ar_rdid",     RdId,     0);
    chk("ar_overflow", Overflow, 0);
    #1;
    Rest = 1'b1;
    @(posedge Clk);
    #1;
    RdReq = '0;
    chk("ar_post_valid", RdValid,   2'b11);
    chk("ar_post_rdid0", RdId[4:0], 1);
    chk("ar_post_rdid1", RdId[9:5], 5);
    chk("ar_post_count", Count,     6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
